// File: rtl/counter_pkg.sv
// Shared types for the timer/event counter: terminal-count modes and
// count-direction encodings.
package counter_pkg;

  typedef enum logic [1:0] {
    WRAP        = 2'd0,
    SATURATE    = 2'd1,
    ONE_SHOT    = 2'd2,
    AUTO_RELOAD = 2'd3
  } mode_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/counter_prescaler.sv
// Clock prescaler: emits a one-clock tick every prescale+1 enabled clocks.
// The count freezes while enable is low; clear restarts the count from 0.
module counter_prescaler #(
  parameter int unsigned PRESCALE_WIDTH = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      clear,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      tick
);

  logic [PRESCALE_WIDTH-1:0] pc_q, pc_d;

  // Using >= means lowering prescale below the current count fires at once.
  assign tick = enable && (pc_q >= prescale);

  always_comb begin
    pc_d = pc_q;
    if (clear) begin
      pc_d = '0;
    end else if (enable) begin
      pc_d = tick ? '0 : pc_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/timer_counter.sv
// Parametrised up/down timer/event counter with prescaler, four
// terminal-count modes, a registered terminal pulse and a sticky irq.
module timer_counter
  import counter_pkg::*;
#(
  parameter int unsigned       WIDTH          = 8,
  parameter int unsigned       PRESCALE_WIDTH = 8,
  parameter logic [WIDTH-1:0]  RESET_VALUE    = '0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      decrement,
  input  logic [1:0]                mode,
  input  logic                      setvalue,
  input  logic [WIDTH-1:0]          valuein,
  input  logic [WIDTH-1:0]          reloadvalue,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      irqclear,
  output logic [WIDTH-1:0]          valueout,
  output logic                      terminal,
  output logic                      attermainal,
  output logic                      running,
  output logic                      irq
);

  logic [WIDTH-1:0] value_q, value_d;
  logic             term_q, term_d;
  logic             irq_q, irq_d;
  logic             run_q, run_d;
  logic             sat_q, sat_d;
  logic             tick;
  logic             at_term;
  logic [WIDTH-1:0] term_value;
  mode_e            mode_sel;

  counter_prescaler #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_prescaler (
    .clock   (clock),
    .reset   (reset),
    .enable  (enable),
    .clear   (setvalue),
    .prescale(prescale),
    .tick    (tick)
  );

  assign mode_sel   = mode_e'(mode);
  assign term_value = (decrement == DIR_DOWN) ? '0 : '1;
  assign at_term    = (value_q == term_value);

  always_comb begin
    value_d = value_q;
    term_d  = 1'b0;
    run_d   = run_q;
    sat_d   = sat_q;

    if (setvalue) begin
      value_d = valuein;
      run_d   = 1'b1;
      sat_d   = 1'b0;
    end else if (tick) begin
      if (at_term) begin
        unique case (mode_sel)
          WRAP: begin
            value_d = (decrement == DIR_DOWN) ? '1 : '0;
            term_d  = 1'b1;
          end
          SATURATE: begin
            term_d = ~sat_q;
            sat_d  = 1'b1;
          end
          ONE_SHOT: begin
            term_d = run_q;
            run_d  = 1'b0;
          end
          AUTO_RELOAD: begin
            value_d = reloadvalue;
            term_d  = 1'b1;
          end
          default: ;
        endcase
      end else if (!(mode_sel == ONE_SHOT && !run_q)) begin
        // Any value-changing tick leaves saturation, e.g. after a direction flip.
        value_d = (decrement == DIR_DOWN) ? value_q - 1'b1 : value_q + 1'b1;
        sat_d   = 1'b0;
      end
    end

    // A pulse in the same clock as irqclear keeps the flag set.
    irq_d = term_d | (irq_q & ~irqclear);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      value_q <= RESET_VALUE;
      term_q  <= 1'b0;
      irq_q   <= 1'b0;
      run_q   <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      value_q <= value_d;
      term_q  <= term_d;
      irq_q   <= irq_d;
      run_q   <= run_d;
      sat_q   <= sat_d;
    end
  end

  assign valueout    = value_q;
  assign terminal    = term_q;
  assign attermainal = at_term;
  assign running     = (mode_sel == ONE_SHOT) ? run_q : enable;
  assign irq         = irq_q;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: each terminal-count mode, prescaler
// freeze, irq set/clear priority and asynchronous reset.
module tb_timer_counter;

  logic       clock;
  logic       reset;
  logic       enable;
  logic       decrement;
  logic [1:0] mode;
  logic       setvalue;
  logic [7:0] valuein;
  logic [7:0] reloadvalue;
  logic [7:0] prescale;
  logic       irqclear;
  logic [7:0] valueout;
  logic       terminal;
  logic       attermainal;
  logic       running;
  logic       irq;

  int unsigned n_checks;
  int unsigned n_errors;
  int unsigned pulses;

  timer_counter #(
    .WIDTH         (8),
    .PRESCALE_WIDTH(8),
    .RESET_VALUE   (8'h3C)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .decrement  (decrement),
    .mode       (mode),
    .setvalue   (setvalue),
    .valuein    (valuein),
    .reloadvalue(reloadvalue),
    .prescale   (prescale),
    .irqclear   (irqclear),
    .valueout   (valueout),
    .terminal   (terminal),
    .attermainal(attermainal),
    .running    (running),
    .irq        (irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    reset       = 1'b1;
    enable      = 1'b0;
    decrement   = 1'b0;
    mode        = 2'd0;
    setvalue    = 1'b0;
    valuein     = 8'h00;
    reloadvalue = 8'h00;
    prescale    = 8'h00;
    irqclear    = 1'b0;

    // Reset state
    #12;
    check("rst_value", valueout, 8'h3C);
    check("rst_term", terminal, 1'b0);
    check("rst_irq", irq, 1'b0);
    check("rst_running", running, 1'b0);
    check("rst_atterm", attermainal, 1'b0);
    reset = 1'b0;

    // WRAP up, prescale 0
    enable = 1'b1; setvalue = 1'b1; valuein = 8'hFD;
    step(1);
    check("wrap_load", valueout, 8'hFD);
    check("wrap_load_term", terminal, 1'b0);
    setvalue = 1'b0;
    step(1);
    check("wrap_fe", valueout, 8'hFE);
    step(1);
    check("wrap_ff", valueout, 8'hFF);
    check("wrap_ff_atterm", attermainal, 1'b1);
    check("wrap_ff_term", terminal, 1'b0);
    step(1);
    check("wrap_00", valueout, 8'h00);
    check("wrap_00_term", terminal, 1'b1);
    check("wrap_irq", irq, 1'b1);
    step(1);
    check("wrap_01", valueout, 8'h01);
    check("wrap_01_term", terminal, 1'b0);
    check("wrap_irq_sticky", irq, 1'b1);
    irqclear = 1'b1;
    step(1);
    check("irq_cleared", irq, 1'b0);
    irqclear = 1'b0;

    // WRAP down, prescale 3, enable freeze
    decrement = 1'b1; prescale = 8'd3; setvalue = 1'b1; valuein = 8'h01;
    step(1);
    check("wdn_load", valueout, 8'h01);
    setvalue = 1'b0;
    step(3);
    check("wdn_wait3", valueout, 8'h01);
    step(1);
    check("wdn_00", valueout, 8'h00);
    check("wdn_00_term", terminal, 1'b0);
    step(3);
    check("wdn_hold00", valueout, 8'h00);
    check("wdn_atterm", attermainal, 1'b1);
    enable = 1'b0;
    step(5);
    check("wdn_frozen", valueout, 8'h00);
    check("wdn_frozen_term", terminal, 1'b0);
    enable = 1'b1;
    step(1);
    check("wdn_ff", valueout, 8'hFF);
    check("wdn_ff_term", terminal, 1'b1);
    step(1);
    check("wdn_term_once", terminal, 1'b0);

    // SATURATE up
    mode = 2'd1; decrement = 1'b0; prescale = 8'd0;
    setvalue = 1'b1; valuein = 8'hFE; irqclear = 1'b1;
    step(1);
    check("sat_load", valueout, 8'hFE);
    check("sat_irq_clr", irq, 1'b0);
    setvalue = 1'b0; irqclear = 1'b0;
    step(1);
    check("sat_ff", valueout, 8'hFF);
    check("sat_ff_term", terminal, 1'b0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (terminal) pulses++;
    end
    check("sat_pulses", pulses, 1);
    check("sat_hold", valueout, 8'hFF);
    decrement = 1'b1;
    step(1);
    check("sat_flip_fe", valueout, 8'hFE);
    check("sat_flip_term", terminal, 1'b0);
    decrement = 1'b0;
    step(1);
    check("sat_back_ff", valueout, 8'hFF);
    check("sat_back_term", terminal, 1'b0);
    step(1);
    check("sat_repulse", terminal, 1'b1);
    step(1);
    check("sat_repulse_end", terminal, 1'b0);

    // ONE_SHOT down
    mode = 2'd2; decrement = 1'b1; setvalue = 1'b1; valuein = 8'h03;
    step(1);
    check("os_load", valueout, 8'h03);
    check("os_running", running, 1'b1);
    setvalue = 1'b0;
    step(3);
    check("os_00", valueout, 8'h00);
    check("os_00_term", terminal, 1'b0);
    step(1);
    check("os_pulse", terminal, 1'b1);
    check("os_stopped", running, 1'b0);
    check("os_hold", valueout, 8'h00);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      if (terminal) pulses++;
    end
    check("os_no_repulse", pulses, 0);
    check("os_still00", valueout, 8'h00);
    setvalue = 1'b1; valuein = 8'h02;
    step(1);
    check("os_rearm", running, 1'b1);
    setvalue = 1'b0;
    step(1);
    check("os_rearm_01", valueout, 8'h01);

    // AUTO_RELOAD down, irq set/clear priority
    mode = 2'd3; reloadvalue = 8'h05; setvalue = 1'b1; valuein = 8'h01;
    step(1);
    check("ar_load", valueout, 8'h01);
    setvalue = 1'b0;
    step(1);
    check("ar_00", valueout, 8'h00);
    check("ar_00_term", terminal, 1'b0);
    step(1);
    check("ar_reload", valueout, 8'h05);
    check("ar_reload_term", terminal, 1'b1);
    step(5);
    check("ar_back00", valueout, 8'h00);
    check("ar_back00_term", terminal, 1'b0);
    irqclear = 1'b1;
    step(1);
    check("ar_reload2", valueout, 8'h05);
    check("ar_reload2_term", terminal, 1'b1);
    check("ar_set_wins", irq, 1'b1);
    irqclear = 1'b0;
    step(1);
    check("ar_04", valueout, 8'h04);
    irqclear = 1'b1;
    step(1);
    check("ar_irq_clr", irq, 1'b0);
    irqclear = 1'b0;
    step(4);
    check("ar_reload3", valueout, 8'h05);
    check("ar_irq_again", irq, 1'b1);

    // Asynchronous reset between edges
    #2;
    reset = 1'b1;
    #1;
    check("arst_value", valueout, 8'h3C);
    check("arst_irq", irq, 1'b0);
    check("arst_term", terminal, 1'b0);
    reset = 1'b0;

    // Load and tick in the same cycle: load wins
    mode = 2'd0; decrement = 1'b0; prescale = 8'd0;
    setvalue = 1'b1; valuein = 8'h40;
    step(1);
    check("ld_wins", valueout, 8'h40);
    check("ld_wins_term", terminal, 1'b0);
    setvalue = 1'b0;
    step(1);
    check("ld_then_inc", valueout, 8'h41);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
